// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI definitions for the ysyx_23060203 memory responders and cache initiators.
package ysyx_23060203_axi_pkg;

    localparam int unsigned AXI_ID_W = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // One-hot read-responder states; ST_WAIT only reachable with random stalls enabled.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_DATA = 3'b010,
        ST_WAIT = 3'b100
    } state_t;

    // WRAP bursts are legal only for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_23060203_axi_rd_responder_if.sv
// AXI4 read-channel link (AR + R) between an initiator and a memory-side responder.
interface axi_if;

    logic                                         arvalid;
    logic                                         arready;
    logic [31:0]                                  araddr;
    logic [ysyx_23060203_axi_pkg::AXI_ID_W-1:0]   arid;
    logic [7:0]                                   arlen;
    logic [2:0]                                   arsize;
    logic [1:0]                                   arburst;

    logic                                         rvalid;
    logic                                         rready;
    logic [31:0]                                  rdata;
    logic [1:0]                                   rresp;
    logic                                         rlast;
    logic [ysyx_23060203_axi_pkg::AXI_ID_W-1:0]   rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

    // Memory-side view, same directions as slave; name used by existing memory modules.
    modport in (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/ysyx_23060203_axi_rd_responder_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used to generate bus stall patterns.
module ysyx_23060203_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr
);

    // Shift one step every cycle; reseeded by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

endmodule

// File: rtl/ysyx_23060203_axi_rd_responder.sv
// AXI4 read responder backed by a word-wide on-chip memory model.
// One burst outstanding at a time, 1-cycle AR->R latency, 1 beat/cycle.
// Define AXI_RD_DELAY_EN to add LFSR-driven arready gating and inter-beat stalls.
module ysyx_23060203_axi_rd_responder
  import ysyx_23060203_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned DEPTH_W   = 12,
  parameter string       INIT_FILE = "",
  parameter int unsigned DLY_W     = 2
) (
  input logic clock,
  input logic reset,
  axi_if.in   mem_r
);

  localparam logic [31:0] MEM_BYTES = 32'd4 << DEPTH_W;

  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  state_t                state_q, state_d;
  logic [AXI_ID_W-1:0]   id_q;
  logic [7:0]            len_q, cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [31:0]           addr_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  resp_t                 rresp_q;
  logic                  rlast_q;
  logic                  ready_en_q;
  logic                  ar_gate;
  logic                  ar_hs, r_hs;

  logic [31:0]           nxt_addr, beat_addr, beat_off, beat_word;
  logic [DEPTH_W-1:0]    beat_idx;
  logic                  start_err, beat_err, beat_ok;

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] mask;
    step = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) * step) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
      default:     next_addr = addr + step;
    endcase
  endfunction

  // Burst-wide errors decided once at AR time; range errors are checked per beat.
  function automatic logic burst_bad(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic        bad;
    step = 32'd1 << size;
    bad  = (size > 3'd2) || (burst == 2'b11);
    if (burst == BURST_WRAP)
      bad = bad || !wrap_len_ok(len) || ((addr & (step - 32'd1)) != 32'd0);
    return bad;
  endfunction

`ifdef AXI_RD_DELAY_EN
  logic [15:0]      lfsr;
  logic [DLY_W-1:0] dly_q;
  logic [DLY_W-1:0] dly_pick;

  ysyx_23060203_lfsr16 #(.SEED(16'hACE1)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign ar_gate  = lfsr[0];
  assign dly_pick = lfsr[DLY_W-1:0];

  // Stall counter: loaded at each non-last R handshake, counts down in ST_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       dly_q <= '0;
    else if (r_hs && !rlast_q)       dly_q <= dly_pick - DLY_W'(1);
    else if (state_q == ST_WAIT)     dly_q <= dly_q - DLY_W'(1);
  end
`else
  assign ar_gate = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_r.arready = (state_q == ST_IDLE) && ready_en_q && ar_gate;
    mem_r.rvalid  = (state_q == ST_DATA);
    ar_hs         = mem_r.arvalid && mem_r.arready;
    r_hs          = mem_r.rvalid && mem_r.rready;
    case (state_q)
      ST_IDLE: if (ar_hs) state_d = ST_DATA;
      ST_DATA: begin
        if (r_hs) begin
          if (rlast_q) state_d = ST_IDLE;
`ifdef AXI_RD_DELAY_EN
          else if (dly_pick != '0) state_d = ST_WAIT;
`endif
        end
      end
`ifdef AXI_RD_DELAY_EN
      ST_WAIT: if (dly_q == '0) state_d = ST_DATA;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Address/lookup of the beat about to be loaded (first beat on AR, next beat on R).
  always_comb begin
    nxt_addr  = next_addr(addr_q, len_q, size_q, burst_q);
    start_err = burst_bad(mem_r.araddr, mem_r.arlen, mem_r.arsize, mem_r.arburst);
    beat_addr = ar_hs ? mem_r.araddr : nxt_addr;
    beat_err  = ar_hs ? start_err : err_q;
    beat_off  = beat_addr - ADDR_BASE;
    beat_idx  = beat_off[DEPTH_W+1:2];
    beat_word = mem[beat_idx];
    beat_ok   = !beat_err && (beat_off < MEM_BYTES);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en_q <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (ar_hs) begin
        id_q    <= mem_r.arid;
        len_q   <= mem_r.arlen;
        size_q  <= mem_r.arsize;
        burst_q <= mem_r.arburst;
        addr_q  <= mem_r.araddr;
        err_q   <= start_err;
        cnt_q   <= '0;
        rlast_q <= (mem_r.arlen == 8'd0);
        rdata_q <= beat_ok ? beat_word : '0;
        rresp_q <= beat_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_hs && !rlast_q) begin
        addr_q  <= nxt_addr;
        cnt_q   <= cnt_q + 8'd1;
        rlast_q <= ((cnt_q + 8'd1) == len_q);
        rdata_q <= beat_ok ? beat_word : '0;
        rresp_q <= beat_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign mem_r.rdata = rdata_q;
  assign mem_r.rresp = rresp_q;
  assign mem_r.rlast = rlast_q;
  assign mem_r.rid   = id_q;

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_responder.sv
// Randomized + directed bench for the AXI read responder with a burst-level reference model.
`timescale 1ns/1ps
module tb_ysyx_23060203_axi_rd_responder;
    import ysyx_23060203_axi_pkg::*;

    localparam logic [31:0]     BASE      = 32'h8000_0000;
    localparam int unsigned     DEPTH_W   = 12;
    localparam longint unsigned MEM_BYTES = 64'd4 << DEPTH_W;

    typedef struct {
        logic [31:0]         data;
        logic [1:0]          resp;
        logic                last;
        logic [AXI_ID_W-1:0] id;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    axi_if mem_r();

    ysyx_23060203_axi_rd_responder #(
        .ADDR_BASE (BASE),
        .DEPTH_W   (DEPTH_W),
        .INIT_FILE (""),
        .DLY_W     (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mem_r (mem_r)
    );

    always #5 clock = ~clock;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned rready_pct    = 100;
    bit          rready_manual = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: enumerate every beat of a burst straight from the address rules.
    function automatic void model_burst(logic [31:0] addr, int unsigned len, int unsigned size,
                                        int unsigned burst, int unsigned id);
        longint unsigned step, total, base, a, a0;
        bit              bad;
        beat_t           b;
        a0    = 64'(addr);
        step  = 64'd1 << size;
        bad   = (size > 2) || (burst == 3) ||
                (burst == 2 && !((len inside {1, 3, 7, 15}) && (a0 % step == 0)));
        for (int unsigned i = 0; i <= len; i++) begin
            case (burst)
                0: a = a0;
                2: begin
                    total = 64'(len + 1) * step;
                    base  = a0 - (a0 % total);
                    a     = base + ((a0 - base + 64'(i) * step) % total);
                end
                default: a = (a0 + 64'(i) * step) & 64'hFFFF_FFFF;
            endcase
            b.id   = AXI_ID_W'(id);
            b.last = (i == len);
            if (!bad && a >= 64'(BASE) && a < 64'(BASE) + MEM_BYTES) begin
                b.data = 32'h1000_0000 + 32'((a - 64'(BASE)) >> 2);
                b.resp = 2'b00;
            end else begin
                b.data = 32'h0;
                b.resp = 2'b10;
            end
            exp_q.push_back(b);
        end
    endfunction

    // Compare process: every R handshake against the model, plus hold-while-stalled rules.
    bit    stall_prev = 1'b0;
    beat_t held;
    always @(negedge clock) begin
        beat_t cur, e;
        if (!reset) begin
            cur.data = mem_r.rdata;
            cur.resp = mem_r.rresp;
            cur.last = mem_r.rlast;
            cur.id   = mem_r.rid;
            if (mem_r.rvalid) chk("arready_during_burst", 32'(mem_r.arready), 32'd0);
            if (stall_prev && mem_r.rvalid) begin
                chk("hold_rdata", cur.data, held.data);
                chk("hold_rresp", 32'(cur.resp), 32'(held.resp));
                chk("hold_rlast", 32'(cur.last), 32'(held.last));
                chk("hold_rid",   32'(cur.id),   32'(held.id));
            end
            if (mem_r.rvalid && mem_r.rready) begin
                obs_q.push_back(cur);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_beat: got rdata %h, expected no beat", cur.data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", cur.data, e.data);
                    chk("rresp", 32'(cur.resp), 32'(e.resp));
                    chk("rlast", 32'(cur.last), 32'(e.last));
                    chk("rid",   32'(cur.id),   32'(e.id));
                end
            end
            stall_prev = mem_r.rvalid && !mem_r.rready;
            held       = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Random rready unless a directed test drives it itself.
    always @(posedge clock) begin
        #1;
        if (!rready_manual) mem_r.rready = ($urandom_range(0, 99) < rready_pct);
    end

    task automatic send_ar(logic [31:0] addr, int unsigned len, int unsigned size,
                           int unsigned burst, int unsigned id);
        int unsigned waited;
        bit          done;
        waited = 0;
        done   = 1'b0;
        @(posedge clock); #1;
        mem_r.araddr  = addr;
        mem_r.arlen   = 8'(len);
        mem_r.arsize  = 3'(size);
        mem_r.arburst = 2'(burst);
        mem_r.arid    = AXI_ID_W'(id);
        mem_r.arvalid = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (mem_r.arready) begin
                model_burst(addr, len, size, burst, id);
                done = 1'b1;
            end else if (++waited > 500) begin
                chk("ar_accept_timeout", 32'(mem_r.arready), 32'd1);
                done = 1'b1;
            end
        end
        @(posedge clock); #1;
        mem_r.arvalid = 1'b0;
    endtask

    task automatic drain();
        int unsigned c;
        c = 0;
        while (exp_q.size() != 0 && c < 4000) begin
            @(negedge clock);
            c++;
        end
        chk("beats_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clock);
    endtask

    task automatic wait_obs(int unsigned n);
        int unsigned c;
        c = 0;
        while (obs_q.size() < n && c < 500) begin
            @(posedge clock);
            c++;
        end
        if (obs_q.size() < n) chk("wait_beat_timeout", 32'(obs_q.size()), 32'(n));
    endtask

    // Directed expectations: beat i data is d[127-32i -: 32], resp is r[7-2i -: 2].
    function automatic void check_obs(string tag, int unsigned n, logic [127:0] d,
                                      logic [7:0] r, int unsigned id);
        chk({tag, "_beats"}, 32'(obs_q.size()), 32'(n));
        for (int unsigned i = 0; i < n && i < obs_q.size(); i++) begin
            chk($sformatf("%s_b%0d_rdata", tag, i), obs_q[i].data, d[127-32*i -: 32]);
            chk($sformatf("%s_b%0d_rresp", tag, i), 32'(obs_q[i].resp), 32'(r[7-2*i -: 2]));
            chk($sformatf("%s_b%0d_rlast", tag, i), 32'(obs_q[i].last), 32'(i == n - 1));
            chk($sformatf("%s_b%0d_rid",   tag, i), 32'(obs_q[i].id), 32'(id));
        end
    endfunction

    initial begin
        int unsigned b, sz, ln, sel;
        logic [31:0] ad;

        mem_r.arvalid = 1'b0;
        mem_r.araddr  = '0;
        mem_r.arid    = '0;
        mem_r.arlen   = '0;
        mem_r.arsize  = '0;
        mem_r.arburst = '0;
        mem_r.rready  = 1'b0;
        for (int i = 0; i < (1 << DEPTH_W); i++) dut.mem[i] = 32'h1000_0000 + 32'(i);

        repeat (3) @(posedge clock);
        #1;
        chk("reset_arready", 32'(mem_r.arready), 32'd0);
        chk("reset_rvalid",  32'(mem_r.rvalid),  32'd0);
        chk("reset_rlast",   32'(mem_r.rlast),   32'd0);
        chk("reset_rresp",   32'(mem_r.rresp),   32'd0);
        chk("reset_rdata",   mem_r.rdata,        32'd0);
        chk("reset_rid",     32'(mem_r.rid),     32'd0);
        reset = 1'b0;
        rready_pct = 100;

        obs_q.delete(); send_ar(BASE + 32'h10, 3, 2, 1, 2); drain();
        check_obs("incr4", 4, {32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007}, 8'h00, 2);

        obs_q.delete(); send_ar(BASE + 32'h18, 3, 2, 2, 3); drain();
        check_obs("wrap4", 4, {32'h1000_0006, 32'h1000_0007, 32'h1000_0004, 32'h1000_0005}, 8'h00, 3);

        obs_q.delete(); send_ar(BASE + 32'h04, 1, 2, 2, 4); drain();
        check_obs("wrap2", 2, {32'h1000_0001, 32'h1000_0000, 64'd0}, 8'h00, 4);

        obs_q.delete(); send_ar(32'h0000_0000, 1, 2, 1, 5); drain();
        check_obs("oob", 2, 128'd0, 8'b1010_0000, 5);

        obs_q.delete(); send_ar(BASE + 32'h3FF8, 3, 2, 1, 6); drain();
        check_obs("top_span", 4, {32'h1000_0FFE, 32'h1000_0FFF, 64'd0}, 8'b0000_1010, 6);

        obs_q.delete(); send_ar(BASE, 2, 2, 2, 7); drain();
        check_obs("wrap_badlen", 3, 128'd0, 8'b1010_1000, 7);

        obs_q.delete(); send_ar(BASE + 32'h20, 0, 3, 1, 8); drain();
        check_obs("size8", 1, 128'd0, 8'b1000_0000, 8);

        // rready stalled for 3 cycles right after the first beat
        rready_manual = 1'b1;
        mem_r.rready  = 1'b1;
        obs_q.delete(); send_ar(BASE + 32'h40, 3, 2, 1, 9);
        wait_obs(1);
        #1 mem_r.rready = 1'b0;
        repeat (3) @(posedge clock);
        #1 mem_r.rready = 1'b1;
        drain();
        rready_manual = 1'b0;
        check_obs("stall", 4, {32'h1000_0010, 32'h1000_0011, 32'h1000_0012, 32'h1000_0013}, 8'h00, 9);

        // reset asserted mid-cycle while beat 2 is pending
        obs_q.delete(); send_ar(BASE + 32'h80, 3, 2, 1, 10);
        wait_obs(1);
        #3 reset = 1'b1;
        #1;
        chk("abort_rvalid",  32'(mem_r.rvalid),  32'd0);
        chk("abort_arready", 32'(mem_r.arready), 32'd0);
        chk("abort_rid",     32'(mem_r.rid),     32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        repeat (5) @(posedge clock);
        chk("abort_beats_seen", 32'(obs_q.size()), 32'd1);
        obs_q.delete(); send_ar(BASE + 32'h20, 1, 2, 1, 1); drain();
        check_obs("post_reset", 2, {32'h1000_0008, 32'h1000_0009, 64'd0}, 8'h00, 1);

        // randomized bursts under random back-pressure
        rready_pct = 70;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 19);
            b   = (sel < 3) ? 0 : (sel < 12) ? 1 : (sel < 19) ? 2 : 3;
            sz  = ($urandom_range(0, 9) < 8) ? 2 : $urandom_range(0, 3);
            ln  = (b == 2 && $urandom_range(0, 9) < 8) ? ((1 << $urandom_range(1, 4)) - 1)
                                                       : $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            if (sel < 7)       ad = BASE + (32'($urandom_range(0, 4095)) << 2);
            else if (sel == 7) ad = BASE + 32'h4000 - (32'($urandom_range(1, 16)) << 2);
            else if (sel == 8) ad = BASE - (32'($urandom_range(0, 8)) << 2);
            else               ad = $urandom;
            if (sz < 2) ad = ad + 32'($urandom_range(0, 3));
            if (b == 2 && $urandom_range(0, 9) < 8) ad = ad & ~((32'd1 << sz) - 32'd1);
            send_ar(ad, ln, sz, b, $urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
